// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg: opcode encoding and instruction field placement for the
// mini CPU core. An instruction is {opcode[3:0], dest, src1, src0}, with
// each operand field ADDR_W bits wide.
package mini_cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LED = 4'd1,
    OP_BLE = 4'd2,
    OP_STO = 4'd3,
    OP_ADD = 4'd4,
    OP_JMP = 4'd5,
    OP_SUB = 4'd6,
    OP_OUT = 4'd7,
    OP_AND = 4'd8,
    OP_OR  = 4'd9,
    OP_XOR = 4'd10,
    OP_SHL = 4'd11,
    OP_SHR = 4'd12,
    OP_BEQ = 4'd13,
    OP_MUL = 4'd14,
    OP_HLT = 4'd15
  } opcode_t;

  function automatic int instrWidth(int addrW);
    return 4 + 3 * addrW;
  endfunction

  function automatic int opcodeLsb(int addrW);
    return 3 * addrW;
  endfunction

  function automatic int destLsb(int addrW);
    return 2 * addrW;
  endfunction

  function automatic int src1Lsb(int addrW);
    return addrW;
  endfunction

  function automatic int src0Lsb(int addrW);
    return 0 * addrW;
  endfunction

endpackage

// File: rtl/mini_cpu_if.sv
// mini_cpu_if: instruction-ROM, LED and output-port signals of the mini CPU
// core. The master modport is the core side; slave is the ROM/peripheral side.
interface mini_cpu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int IP_W   = 16,
  parameter int LED_W  = 8
);
  logic [IP_W-1:0]       oIP;
  logic [3*ADDR_W+3:0]   iInstruction;
  logic [LED_W-1:0]      oLed;
  logic [DATA_W-1:0]     oOutData;
  logic                  oOutValid;
  logic                  iOutReady;
  logic                  oHalted;

  modport master (
    output oIP, oLed, oOutData, oOutValid, oHalted,
    input  iInstruction, iOutReady
  );

  modport slave (
    input  oIP, oLed, oOutData, oOutValid, oHalted,
    output iInstruction, iOutReady
  );
endinterface

// File: rtl/mini_cpu_regfile.sv
// mini_cpu_regfile: 2**ADDR_W x DATA_W register file with two asynchronous
// read ports, one synchronous write port and asynchronous clear.
module mini_cpu_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataB,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];

  // Clear everything on reset; otherwise one write per cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

endmodule

// File: rtl/mini_cpu_core.sv
// mini_cpu_core: two-stage (fetch/execute) register-file CPU core with an
// LED register and a one-entry valid/ready output port.
// Optional feature: define MINI_CPU_MUL_EN to make opcode 14 a multiply;
// otherwise opcode 14 behaves as NOP and no multiplier is built.
module mini_cpu_core
  import mini_cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int IP_W   = 16,
  parameter int LED_W  = 8
) (
  input logic        Clock,
  input logic        Reset,
  mini_cpu_if.master bus
);
  localparam int INSTR_W  = instrWidth(ADDR_W);
  localparam int OP_LSB   = opcodeLsb(ADDR_W);
  localparam int DEST_LSB = destLsb(ADDR_W);
  localparam int SRC1_LSB = src1Lsb(ADDR_W);
  localparam int SRC0_LSB = src0Lsb(ADDR_W);
  localparam int SH_W     = $clog2(DATA_W);
  // All-zero instruction decodes as NOP; used for reset and branch bubbles.
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  logic [INSTR_W-1:0] decodeInstr_p1;
  logic [IP_W-1:0]    ipReg;
  logic [LED_W-1:0]   ledReg;
  logic [DATA_W-1:0]  outData;
  logic               outValid;
  logic               halted;

  opcode_t            op;
  logic [ADDR_W-1:0]  dest, src1, src0;
  logic [DATA_W-1:0]  opA, opB, wrData;
  logic [IP_W-1:0]    branchTarget;
  logic               wrEn, branchTaken, stall;

  assign op           = opcode_t'(decodeInstr_p1[OP_LSB +: 4]);
  assign dest         = decodeInstr_p1[DEST_LSB +: ADDR_W];
  assign src1         = decodeInstr_p1[SRC1_LSB +: ADDR_W];
  assign src0         = decodeInstr_p1[SRC0_LSB +: ADDR_W];
  assign branchTarget = IP_W'(dest);

  // An OUT cannot retire while the buffer is full and not draining this edge.
  assign stall = !halted && (op == OP_OUT) && outValid && !bus.iOutReady;

  mini_cpu_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) regFile (
    .Clock   (Clock),
    .Reset   (Reset),
    .rdAddrA (src1),
    .rdDataA (opA),
    .rdAddrB (src0),
    .rdDataB (opB),
    .wrEn    (wrEn),
    .wrAddr  (dest),
    .wrData  (wrData)
  );

  // Execute stage: register write-back value and branch decision.
  always_comb begin
    wrEn        = 1'b0;
    wrData      = '0;
    branchTaken = 1'b0;
    case (op)
      OP_BLE: branchTaken = (opA <= opB);
      OP_JMP: branchTaken = 1'b1;
      OP_BEQ: branchTaken = (opA == opB);
      OP_STO: begin wrEn = 1'b1; wrData = DATA_W'({src1, src0}); end
      OP_ADD: begin wrEn = 1'b1; wrData = opA + opB; end
      OP_SUB: begin wrEn = 1'b1; wrData = opA - opB; end
      OP_AND: begin wrEn = 1'b1; wrData = opA & opB; end
      OP_OR:  begin wrEn = 1'b1; wrData = opA | opB; end
      OP_XOR: begin wrEn = 1'b1; wrData = opA ^ opB; end
      OP_SHL: begin wrEn = 1'b1; wrData = opA << opB[SH_W-1:0]; end
      OP_SHR: begin wrEn = 1'b1; wrData = opA >> opB[SH_W-1:0]; end
`ifdef MINI_CPU_MUL_EN
      OP_MUL: begin wrEn = 1'b1; wrData = opA * opB; end
`endif
      default: ;
    endcase
    // Once halted the frozen decode register must have no further effect.
    if (halted) begin
      wrEn        = 1'b0;
      branchTaken = 1'b0;
    end
  end

  // Fetch/execute boundary: IP, decode register, LED, output port, halt flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ipReg          <= '0;
      decodeInstr_p1 <= NOP_INSTR;
      ledReg         <= '0;
      outData        <= '0;
      outValid       <= 1'b0;
      halted         <= 1'b0;
    end else begin
      if (outValid && bus.iOutReady) outValid <= 1'b0;
      if (!halted && !stall) begin
        if (op == OP_HLT) begin
          halted <= 1'b1;
        end else begin
          ipReg          <= branchTaken ? branchTarget : ipReg + IP_W'(1);
          decodeInstr_p1 <= branchTaken ? NOP_INSTR : bus.iInstruction;
        end
        if (op == OP_LED) ledReg <= opA[LED_W-1:0];
        // Refill on the same edge as a transfer keeps the buffer valid.
        if (op == OP_OUT) begin
          outData  <= opA;
          outValid <= 1'b1;
        end
      end
    end
  end

  assign bus.oIP       = ipReg;
  assign bus.oLed      = ledReg;
  assign bus.oOutData  = outData;
  assign bus.oOutValid = outValid;
  assign bus.oHalted   = halted;

endmodule

// File: tb/tb_mini_cpu_core.sv
// tb_mini_cpu_core: directed and random programs for mini_cpu_core, checked
// against an instruction-level model of the ISA.
module tb_mini_cpu_core;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int IP_W    = 16;
  localparam int LED_W   = 8;
  localparam int ROM_D   = 256;
  localparam int TRACE_D = 1024;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  mini_cpu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IP_W(IP_W), .LED_W(LED_W)) bus ();

  mini_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IP_W(IP_W), .LED_W(LED_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  logic [27:0] rom [ROM_D];
  always_comb bus.iInstruction = (bus.oIP < IP_W'(ROM_D)) ? rom[bus.oIP[7:0]] : 28'h0;

  int nChecks = 0;
  int nErrors = 0;

  logic [15:0] gotOut[$];
  int          xferCyc[$];
  logic [15:0] ipTrace    [TRACE_D];
  logic [7:0]  ledTrace   [TRACE_D];
  logic        validTrace [TRACE_D];

  logic [15:0] expOut[$];
  logic [7:0]  expLed;
  logic [15:0] expHaltIp;

  task automatic checkEq(string tag, logic [31:0] got, logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] ins(int op, int d, int s1, int s0);
    return {op[3:0], d[7:0], s1[7:0], s0[7:0]};
  endfunction

  task automatic fillRom(logic [27:0] w);
    for (int i = 0; i < ROM_D; i++) rom[i] = w;
  endtask

  // Instruction-level model: executes the program one instruction at a time.
  task automatic modelRun();
    logic [15:0] r [256];
    logic [27:0] w;
    int pc, nextPc, op, d, s1, s0;
    bit stop;
    for (int i = 0; i < 256; i++) r[i] = 16'h0;
    expOut.delete();
    expLed = 8'h0;
    expHaltIp = 16'h0;
    pc = 0;
    stop = 0;
    for (int step = 0; step < 4000 && !stop; step++) begin
      w = (pc < ROM_D) ? rom[pc] : 28'h0;
      op = int'(w[27:24]); d = int'(w[23:16]); s1 = int'(w[15:8]); s0 = int'(w[7:0]);
      nextPc = (pc + 1) % 65536;
      case (op)
        1:  expLed = r[s1][7:0];
        2:  if (r[s1] <= r[s0]) nextPc = d;
        3:  r[d] = w[15:0];
        4:  r[d] = r[s1] + r[s0];
        5:  nextPc = d;
        6:  r[d] = r[s1] - r[s0];
        7:  expOut.push_back(r[s1]);
        8:  r[d] = r[s1] & r[s0];
        9:  r[d] = r[s1] | r[s0];
        10: r[d] = r[s1] ^ r[s0];
        11: r[d] = r[s1] << (r[s0] % 16);
        12: r[d] = r[s1] >> (r[s0] % 16);
        13: if (r[s1] == r[s0]) nextPc = d;
        14: begin
`ifdef MINI_CPU_MUL_EN
          r[d] = 16'((longint'(r[s1]) * longint'(r[s0])) % 65536);
`endif
        end
        15: begin stop = 1; expHaltIp = 16'((pc + 1) % 65536); end
        default: ;
      endcase
      pc = nextPc;
    end
  endtask

  function automatic logic readyFor(int mode, int from, int edgeNo);
    if (mode == 0) return 1'b1;
    if (mode == 1) return logic'($urandom_range(0, 1));
    return edgeNo >= from;
  endfunction

  // Reset the core, then run until halted and drained (or the budget runs out).
  task automatic runProgram(string tag, int mode, int from, int maxCyc);
    int cyc;
    bit done;
    gotOut.delete();
    xferCyc.delete();
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    checkEq({tag, ".rstIp"},    32'(bus.oIP), 0);
    checkEq({tag, ".rstLed"},   32'(bus.oLed), 0);
    checkEq({tag, ".rstData"},  32'(bus.oOutData), 0);
    checkEq({tag, ".rstValid"}, 32'(bus.oOutValid), 0);
    checkEq({tag, ".rstHalt"},  32'(bus.oHalted), 0);
    @(negedge Clock);
    Reset = 1'b0;
    bus.iOutReady = readyFor(mode, from, 1);
    cyc = 0;
    done = 0;
    while (cyc < maxCyc && !done) begin
      @(posedge Clock);
      cyc++;
      @(negedge Clock);
      if (cyc < TRACE_D) begin
        ipTrace[cyc]    = bus.oIP;
        ledTrace[cyc]   = bus.oLed;
        validTrace[cyc] = bus.oOutValid;
      end
      if (bus.oHalted && !bus.oOutValid) done = 1;
      bus.iOutReady = readyFor(mode, from, cyc + 1);
      if (bus.oOutValid && bus.iOutReady) begin
        gotOut.push_back(bus.oOutData);
        xferCyc.push_back(cyc + 1);
      end
    end
    checkEq({tag, ".finished"}, 32'(done), 1);
  endtask

  task automatic compareModel(string tag);
    modelRun();
    checkEq({tag, ".nOut"}, gotOut.size(), expOut.size());
    foreach (expOut[i])
      checkEq($sformatf("%s.out%0d", tag, i),
              (i < gotOut.size()) ? 32'(gotOut[i]) : 32'hDEAD_BEEF, 32'(expOut[i]));
    checkEq({tag, ".led"},    32'(bus.oLed), 32'(expLed));
    checkEq({tag, ".haltIp"}, 32'(bus.oIP), 32'(expHaltIp));
    checkEq({tag, ".halted"}, 32'(bus.oHalted), 1);
  endtask

  task automatic loadProgA();
    fillRom(28'h0);
    rom[0]  = ins(3, 1, 0, 5);       // STO R1,5
    rom[1]  = ins(3, 2, 0, 3);       // STO R2,3
    rom[2]  = ins(4, 3, 1, 2);       // ADD R3,R1,R2
    rom[3]  = ins(1, 0, 3, 0);       // LED R3
    rom[4]  = ins(6, 4, 2, 1);       // SUB R4,R2,R1
    rom[5]  = ins(3, 5, 0, 17);      // STO R5,17
    rom[6]  = ins(11, 6, 2, 5);      // SHL R6,R2,R5
    rom[7]  = ins(7, 0, 4, 0);       // OUT R4
    rom[8]  = ins(7, 0, 6, 0);       // OUT R6
    rom[9]  = ins(2, 8'h20, 2, 1);   // BLE R2,R1 -> 0x20
    rom[10] = ins(3, 7, 0, 8'hAA);   // skipped
    rom[32] = ins(13, 8'h30, 1, 2);  // BEQ R1,R2 (not taken)
    rom[33] = ins(3, 10, 1, 8'h2C);  // STO R10,300
    rom[34] = ins(3, 11, 1, 8'h2C);  // STO R11,300
    rom[35] = ins(3, 12, 0, 8'h77);  // STO R12,0x77
    rom[36] = ins(14, 12, 10, 11);   // MUL R12,R10,R11
    rom[37] = ins(7, 0, 12, 0);      // OUT R12
    rom[38] = ins(7, 0, 7, 0);       // OUT R7
    rom[39] = ins(15, 0, 0, 0);      // HLT
    rom[40] = ins(3, 1, 0, 8'h99);   // never executed
    rom[41] = ins(1, 0, 1, 0);       // never executed
  endtask

  task automatic loadProgB();
    fillRom(28'h0);
    rom[0] = ins(3, 1, 0, 8'h11);
    rom[1] = ins(3, 2, 0, 8'h22);
    rom[2] = ins(7, 0, 1, 0);
    rom[3] = ins(7, 0, 2, 0);
    rom[4] = ins(3, 3, 0, 8'h33);
    rom[5] = ins(7, 0, 3, 0);
    rom[6] = ins(15, 0, 0, 0);
  endtask

  // Random body with forward-only branches, then OUT R0..R7 and HLT.
  task automatic genRandom();
    fillRom(ins(15, 0, 0, 0));
    for (int a = 0; a < 31; a++) begin
      int op, d, s1, s0;
      op = $urandom_range(0, 14);
      if ($urandom_range(0, 3) == 0) op = 3;
      d  = $urandom_range(0, 7);
      s1 = $urandom_range(0, 7);
      s0 = $urandom_range(0, 7);
      if (op == 2 || op == 5 || op == 13) d = $urandom_range(a + 1, 31);
      if (op == 3) begin
        s1 = $urandom_range(0, 255);
        s0 = $urandom_range(0, 255);
      end
      rom[a] = ins(op, d, s1, s0);
    end
    for (int r = 0; r < 8; r++) rom[31 + r] = ins(7, 0, r, 0);
    rom[39] = ins(15, 0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iOutReady = 1'b0;
    loadProgB();
    repeat (2) @(posedge Clock);
    #1;
    checkEq("por.ip",    32'(bus.oIP), 0);
    checkEq("por.valid", 32'(bus.oOutValid), 0);
    checkEq("por.halt",  32'(bus.oHalted), 0);

    // Fill the output buffer with ready low, then reset in the middle of the stall.
    @(negedge Clock);
    Reset = 1'b0;
    repeat (7) @(posedge Clock);
    @(negedge Clock);
    checkEq("stall.valid", 32'(bus.oOutValid), 1);
    checkEq("stall.ip",    32'(bus.oIP), 4);
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    checkEq("midRst.valid", 32'(bus.oOutValid), 0);
    checkEq("midRst.ip",    32'(bus.oIP), 0);
    checkEq("midRst.data",  32'(bus.oOutData), 0);

    loadProgA();
    runProgram("A", 0, 0, 300);
    checkEq("A.ledBefore", 32'(ledTrace[4]), 0);
    checkEq("A.ledAdd",    32'(ledTrace[5]), 8);
    checkEq("A.bleTaken",  32'(ipTrace[11]), 32'h20);
    checkEq("A.afterBle",  32'(ipTrace[12]), 32'h21);
    checkEq("A.beqFall",   32'(ipTrace[13]), 32'h22);
    checkEq("A.subWrap",   32'(gotOut.size() > 0 ? gotOut[0] : 16'h0), 32'hFFFE);
    checkEq("A.shl17",     32'(gotOut.size() > 1 ? gotOut[1] : 16'h0), 6);
`ifdef MINI_CPU_MUL_EN
    checkEq("A.mul",       32'(gotOut.size() > 2 ? gotOut[2] : 16'h0), 32'h5F90);
`else
    checkEq("A.mul",       32'(gotOut.size() > 2 ? gotOut[2] : 16'h0), 32'h0077);
`endif
    checkEq("A.skipped",   32'(gotOut.size() > 3 ? gotOut[3] : 16'hFFFF), 0);
    compareModel("A");
    repeat (5) @(posedge Clock);
    @(negedge Clock);
    checkEq("A.ipFrozen", 32'(bus.oIP), 32'h28);
    checkEq("A.ledHeld",  32'(bus.oLed), 8);

    loadProgB();
    runProgram("B", 2, 10, 300);
    checkEq("B.validEarly", 32'(validTrace[3]), 0);
    checkEq("B.validNext",  32'(validTrace[4]), 1);
    checkEq("B.ipHold4",    32'(ipTrace[4]), 4);
    checkEq("B.ipHold9",    32'(ipTrace[9]), 4);
    checkEq("B.ipResume",   32'(ipTrace[10]), 5);
    checkEq("B.xfer0",      xferCyc.size() > 0 ? 32'(xferCyc[0]) : 32'hFFFF, 10);
    checkEq("B.xfer1",      xferCyc.size() > 1 ? 32'(xferCyc[1]) : 32'hFFFF, 11);
    compareModel("B");

    for (int t = 0; t < 15; t++) begin
      genRandom();
      runProgram($sformatf("R%0d", t), 1, 0, 1000);
      compareModel($sformatf("R%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/mini_cpu_core.md
# mini_cpu_core

Parametrised successor of the team's mini ALU datapath: a two-stage (fetch/execute) accumulator-less processor core with an internal register file, configurable data/address/IP widths, a widened opcode set (logic, shifts, equality branches, halt) and a generic one-entry valid/ready output port that replaces the hard-wired LCD stall. It sits between the instruction ROM (driven by `oIP`) and any output peripheral (LCD driver, UART) attached to the output port.

## Interface
- `DATA_W`, 16: register and ALU width (≥8).
- `ADDR_W`, 8: register-file address and instruction field width; depth = 2**ADDR_W.
- `IP_W`, 16: instruction pointer width; must be ≥ ADDR_W.
- `LED_W`, 8: LED port width; must be ≤ DATA_W.
- `Clock` in 1: the single clock; all state changes on rising edge.
- `Reset` in 1: asynchronous, active-high reset; clears all state below.
- `oIP` out IP_W: instruction address to ROM.
- `iInstruction` in 4+3*ADDR_W: {opcode[3:0], dest, src1, src0}; valid combinationally in the same cycle as `oIP`.
- `oLed` out LED_W: LED register.
- `oOutData` out DATA_W: output-port data.
- `oOutValid` out 1: output buffer holds a datum.
- `iOutReady` in 1: sink accepts datum on this edge when `oOutValid` is high.
- `oHalted` out 1: core executed HLT.

## Operation
- Reset values: `oIP`=0, `oLed`=0, `oOutData`=0, `oOutValid`=0, `oHalted`=0, decode register = NOP, all registers = 0.
- Fetch: each cycle `iInstruction` is latched into the decode register; execute stage works on the decode register, reading registers asynchronously.
- Opcodes: 0 NOP; 1 LED (`oLed`<=R[src1][LED_W-1:0]); 2 BLE (branch to dest if R[src1] ≤ R[src0], unsigned); 3 STO (R[dest]<={src1,src0}, zero-extended/truncated to DATA_W); 4 ADD; 5 JMP (to dest); 6 SUB (R[src1]−R[src0]); 7 OUT; 8 AND; 9 OR; 10 XOR; 11 SHL; 12 SHR (logical, shift R[src1] by R[src0][$clog2(DATA_W)-1:0]); 13 BEQ; 14 MUL; 15 HLT.
- Arithmetic: results R[dest] = R[src1] op R[src0], truncated to DATA_W, wrap-around, no flags.
- Branch target = dest zero-extended to IP_W.
- Taken branch/JMP: next `oIP` = target; decode register loaded with NOP (one bubble).
- OUT: if `oOutValid`=0, or `oOutValid`=1 and `iOutReady`=1, load `oOutData`<=R[src1], `oOutValid`<=1, retire. Otherwise stall: `oIP`, decode register, register file all hold.
- Output handshake: transfer on rising edge with `oOutValid`&&`iOutReady`; `oOutValid` drops next cycle unless refilled on the same edge.
- HLT: `oHalted`<=1; `oIP` and decode register freeze; output port keeps draining. Only `Reset` exits.
- Writes to R[dest] become visible to the instruction executed in the next cycle (no forwarding hazard).
- Reset mid-stall or mid-transfer: pending datum discarded, `oOutValid`=0 immediately.

## Timing
- `oIP` increments by 1 per unstalled cycle, wraps at 2**IP_W.
- Instruction at address A executes one cycle after `oIP`=A; its register write lands on the following edge.
- Taken branch costs 2 cycles; fall-through 1 cycle.
- OUT with free buffer: `oOutValid` high the cycle after execute.

## Configuration
- `MINI_CPU_MUL_EN`: when defined, opcode 14 computes R[src1]*R[src0], low DATA_W bits. When undefined, opcode 14 executes as NOP and no multiplier is synthesised.

## Structure
- Package `mini_cpu_pkg`: opcode constants, instruction field offset functions of ADDR_W.
- Sub-module `mini_cpu_regfile` (2 async read ports, 1 sync write port, async clear, depth 2**ADDR_W).

## Test plan
- Reset mid-run, then program STO R1,0x0005; STO R2,0x0003; ADD R3,R1,R2; LED R3 -> `oLed`=0x08 four cycles after first fetch.
- SUB R4,R2,R1 with R2=3, R1=5 -> R4=0xFFFE (wrap); SHL by 17 with DATA_W=16 -> shift by 1.
- BLE taken (3≤5) to address 0x20 -> next `oIP`=0x20, instruction at old IP+1 not executed; BEQ not-taken -> `oIP`+1, no bubble.
- OUT twice with `iOutReady`=0 for 5 cycles -> first datum held, `oIP` frozen 5 cycles; raise ready -> both data delivered in order on consecutive edges.
- HLT followed by STO -> `oHalted`=1, `oIP` constant, STO target unchanged; assert `Reset` -> all outputs 0.
- Opcode 14 with R1=300, R2=300 -> R3=0x5F90 with `MINI_CPU_MUL_EN`; R3 unchanged without it.
